// File: rtl/accumulator_feeder.sv
// accumulator_feeder
// Initiator side of the accumulator interface. Accepts a stream of len words
// over a valid/ready handshake, packs them into WIDTH-lane chunks, sequences
// the accumulator with clear/enable/preserve pulses so that multi-chunk
// streams reduce to one total, and returns that total over a valid/ready port.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   start, len                     stream request (sampled in IDLE only)
//   in_data, in_valid, in_ready    operand word stream
//   acc_vals, acc_en, acc_rst,     accumulator drive: packed lanes, enable,
//   acc_pre                        reset pulse, preserve-sum-across-reset
//   acc_rdy, acc_sum               accumulator result
//   res_data, res_valid, res_ready stream total
//   busy                           high whenever not IDLE
//   err                            RUN timeout, sticky until next accepted start
module accumulator_feeder #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned VARWIDTH = 32,
    parameter int unsigned LENW     = 8,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LENW-1:0]           len,
    input  logic [VARWIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [VARWIDTH*WIDTH-1:0] acc_vals,
    output logic                      acc_en,
    output logic                      acc_rst,
    output logic                      acc_pre,
    input  logic                      acc_rdy,
    input  logic [VARWIDTH-1:0]       acc_sum,
    output logic [VARWIDTH-1:0]       res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      err
);

    localparam int unsigned LANEW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WAITW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FILL, S_RUN, S_CHAIN, S_OUTPUT
    } state_t;

    state_t                          state;
    state_t                          next_state;
    logic [LENW-1:0]                 remaining;
    logic [LANEW-1:0]                lane;
    logic [WAITW-1:0]                wait_cnt;
    logic [WIDTH-1:0][VARWIDTH-1:0]  lanes;

    logic take;
    logic fill_last;
    logic run_timeout;

    assign acc_vals = lanes;

    // A transfer only happens in FILL; the last one closes the chunk.
    assign take        = (state == S_FILL) && in_valid && in_ready;
    assign fill_last   = take && ((lane == LANEW'(WIDTH - 1)) || (remaining == LENW'(1)));
    assign run_timeout = (wait_cnt == WAITW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; acc_rdy wins over a timeout landing on the same cycle
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (len != '0) ? S_CLEAR : S_OUTPUT;
            S_CLEAR:  next_state = S_FILL;
            S_CHAIN:  next_state = S_FILL;
            S_FILL:   if (fill_last) next_state = S_RUN;
            S_RUN: begin
                if (acc_rdy)          next_state = (remaining == '0) ? S_OUTPUT : S_CHAIN;
                else if (run_timeout) next_state = S_OUTPUT;
            end
            S_OUTPUT: if (res_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Registered outputs and datapath; control strobes follow the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            acc_en    <= 1'b0;
            acc_rst   <= 1'b0;
            acc_pre   <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            res_data  <= '0;
            remaining <= '0;
            lane      <= '0;
            wait_cnt  <= '0;
            lanes     <= '0;
        end else begin
            in_ready  <= (next_state == S_FILL);
            acc_en    <= (next_state == S_RUN);
            acc_rst   <= (next_state == S_CLEAR) || (next_state == S_CHAIN);
            acc_pre   <= (next_state == S_CHAIN);
            res_valid <= (next_state == S_OUTPUT);
            busy      <= (next_state != S_IDLE);

            if ((next_state == S_CLEAR) || (next_state == S_CHAIN)) begin
                lanes <= '0;
                lane  <= '0;
            end

            if (state == S_RUN) wait_cnt <= wait_cnt + WAITW'(1);
            else                wait_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        remaining <= len;
                        if (len == '0) res_data <= '0;
                    end
                end
                S_FILL: begin
                    if (take) begin
                        lanes[lane] <= in_data;
                        lane        <= lane + LANEW'(1);
                        remaining   <= remaining - LENW'(1);
                    end
                end
                S_RUN: begin
                    if (acc_rdy) begin
                        if (remaining == '0) res_data <= acc_sum;
                    end else if (run_timeout) begin
                        err      <= 1'b1;
                        res_data <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_feeder.sv
module tb_accumulator_feeder;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned VARWIDTH = 32;
    localparam int unsigned LENW     = 8;
    localparam int unsigned TIMEOUT  = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [LENW-1:0]           len;
    logic [VARWIDTH-1:0]       in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [VARWIDTH*WIDTH-1:0] acc_vals;
    logic                      acc_en;
    logic                      acc_rst;
    logic                      acc_pre;
    logic                      acc_rdy;
    logic [VARWIDTH-1:0]       acc_sum;
    logic [VARWIDTH-1:0]       res_data;
    logic                      res_valid;
    logic                      res_ready;
    logic                      busy;
    logic                      err;

    accumulator_feeder #(
        .WIDTH(WIDTH), .VARWIDTH(VARWIDTH), .LENW(LENW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .acc_vals(acc_vals), .acc_en(acc_en), .acc_rst(acc_rst), .acc_pre(acc_pre),
        .acc_rdy(acc_rdy), .acc_sum(acc_sum),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int applied     = 0;
    int miscompares = 0;

    // Accumulator model: sums all lanes into a running total, answers 3 cycles into RUN
    bit          acc_model_on = 1'b1;
    logic [31:0] acc_run;
    int          acc_wait;

    function automatic logic [31:0] lane_sum(input logic [VARWIDTH*WIDTH-1:0] v);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < int'(WIDTH); k++) s = s + v[k*VARWIDTH +: VARWIDTH];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_rdy  <= 1'b0;
            acc_sum  <= '0;
            acc_run  <= '0;
            acc_wait <= 0;
        end else begin
            acc_rdy <= 1'b0;
            if (acc_rst) begin
                acc_wait <= 0;
                if (!acc_pre) acc_run <= '0;
            end else if (acc_en && !acc_rdy) begin
                acc_wait <= acc_wait + 1;
                if (acc_model_on && acc_wait == 2) begin
                    acc_rdy <= 1'b1;
                    acc_sum <= acc_run + lane_sum(acc_vals);
                    acc_run <= acc_run + lane_sum(acc_vals);
                end
            end
        end
    end

    // Event counters and first-RUN-cycle lane snapshot
    int n_clear = 0, n_chain = 0, n_en = 0, n_overlap = 0, n_xfer = 0;
    logic [VARWIDTH*WIDTH-1:0] snap;
    bit snapped = 1'b0;

    always @(negedge clk) begin
        if (acc_rst && !acc_pre) n_clear++;
        if (acc_rst && acc_pre)  n_chain++;
        if (acc_en)              n_en++;
        if (acc_en && acc_rst)   n_overlap++;
        if (in_valid && in_ready) n_xfer++;
        if (acc_rst) snapped = 1'b0;
        else if (acc_en && !snapped) begin
            snap    = acc_vals;
            snapped = 1'b1;
        end
    end

    function automatic logic [31:0] word(input int mode, input int idx, input logic [31:0] cval);
        if (mode == 0) return 32'(idx + 1);
        if (mode == 1) return 32'(10 * (idx + 1));
        return cval;
    endfunction

    // Issue one stream, feed it, then hold res_ready low for 'hold' cycles before taking the result
    task automatic run_stream(input int n, input int mode, input logic [31:0] cval,
                              input bit gaps, input bit poke_start, input int hold,
                              output logic [31:0] got);
        int idx, cyc;
        bit xfer, stable;
        got = '0;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LENW'(n);
        @(posedge clk); #1;
        start = poke_start;
        len   = LENW'(3);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = word(mode, idx, cval);
            @(negedge clk);
            xfer = in_valid && in_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < n) begin
            applied++; miscompares++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", idx, n);
            return;
        end
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (res_valid !== 1'b1) begin
            applied++; miscompares++;
            $display("FAIL result_timeout: res_valid=%b, required 1", res_valid);
            return;
        end
        got = res_data;
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (res_data !== got || res_valid !== 1'b1) stable = 1'b0;
            end
            applied++;
            if (stable !== 1'b1) begin
                miscompares++;
                $display("FAIL result_hold: res_data=%h valid=%b, required %h held", res_data, res_valid, got);
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        applied++;
        if ({res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL back_to_idle: valid,busy=%b, required 00", {res_valid, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        applied++;
        if ({in_ready, acc_en, acc_rst, acc_pre, res_valid, busy, err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: %b, required 0000000", {in_ready, acc_en, acc_rst, acc_pre, res_valid, busy, err});
        end
        applied++;
        if (acc_vals !== '0 || res_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: res_data=%h, required 0", res_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_chunk();
        logic [31:0] got;
        int c0, h0, x0;
        c0 = n_clear; h0 = n_chain; x0 = n_xfer;
        run_stream(16, 0, '0, 1'b0, 1'b0, 0, got);
        applied++;
        if (got !== 32'd136) begin miscompares++; $display("FAIL full_sum: got %0d, required 136", got); end
        applied++;
        if ((n_clear - c0) !== 1 || (n_chain - h0) !== 0) begin
            miscompares++;
            $display("FAIL full_pulses: clear=%0d chain=%0d, required 1 0", n_clear - c0, n_chain - h0);
        end
        applied++;
        if ((n_xfer - x0) !== 16 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_xfer_err: xfers=%0d err=%b, required 16 0", n_xfer - x0, err);
        end
    endtask

    task automatic test_partial_chunk();
        logic [31:0] got;
        logic [VARWIDTH*WIDTH-1:0] exp;
        exp = '0;
        exp[0*32 +: 32] = 32'd10;
        exp[1*32 +: 32] = 32'd20;
        exp[2*32 +: 32] = 32'd30;
        exp[3*32 +: 32] = 32'd40;
        exp[4*32 +: 32] = 32'd50;
        run_stream(5, 1, '0, 1'b0, 1'b0, 0, got);
        applied++;
        if (got !== 32'd150) begin miscompares++; $display("FAIL partial_sum: got %0d, required 150", got); end
        applied++;
        if (snap !== exp) begin miscompares++; $display("FAIL partial_lanes: got %h, required %h", snap, exp); end
    endtask

    task automatic test_chain();
        logic [31:0] got;
        int c0, h0, x0;
        c0 = n_clear; h0 = n_chain; x0 = n_xfer;
        run_stream(40, 2, 32'd1, 1'b0, 1'b0, 0, got);
        applied++;
        if (got !== 32'd40) begin miscompares++; $display("FAIL chain_sum: got %0d, required 40", got); end
        applied++;
        if ((n_clear - c0) !== 1 || (n_chain - h0) !== 2) begin
            miscompares++;
            $display("FAIL chain_pulses: clear=%0d chain=%0d, required 1 2", n_clear - c0, n_chain - h0);
        end
        applied++;
        if ((n_xfer - x0) !== 40) begin miscompares++; $display("FAIL chain_xfer: got %0d, required 40", n_xfer - x0); end
    endtask

    task automatic test_len_zero();
        logic [31:0] got;
        int e0, r0;
        e0 = n_en; r0 = n_clear + n_chain;
        run_stream(0, 0, '0, 1'b0, 1'b0, 0, got);
        applied++;
        if (got !== 32'd0) begin miscompares++; $display("FAIL len0_sum: got %h, required 0", got); end
        applied++;
        if ((n_en - e0) !== 0 || (n_clear + n_chain - r0) !== 0) begin
            miscompares++;
            $display("FAIL len0_acc: en=%0d rst=%0d, required 0 0", n_en - e0, n_clear + n_chain - r0);
        end
    endtask

    task automatic test_back_to_back_gaps();
        logic [31:0] got;
        int c0, x0;
        c0 = n_clear; x0 = n_xfer;
        run_stream(20, 2, 32'hFFFF_FFFF, 1'b1, 1'b1, 10, got);
        applied++;
        if (got !== 32'hFFFF_FFEC) begin miscompares++; $display("FAIL gaps_sum: got %h, required ffffffec", got); end
        applied++;
        if ((n_xfer - x0) !== 20 || (n_clear - c0) !== 1) begin
            miscompares++;
            $display("FAIL gaps_ignore_start: xfers=%0d clears=%0d, required 20 1", n_xfer - x0, n_clear - c0);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] got;
        int e0;
        e0 = n_en;
        acc_model_on = 1'b0;
        run_stream(3, 0, '0, 1'b0, 1'b0, 0, got);
        acc_model_on = 1'b1;
        applied++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b, required 1", err); end
        applied++;
        if ((n_en - e0) !== int'(TIMEOUT)) begin
            miscompares++;
            $display("FAIL timeout_cycles: got %0d, required %0d", n_en - e0, TIMEOUT);
        end
        applied++;
        if (got !== acc_sum) begin miscompares++; $display("FAIL timeout_data: got %h, required %h", got, acc_sum); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] got;
        @(posedge clk); #1;
        start = 1'b1;
        len   = LENW'(10);
        @(posedge clk); #1;
        start = 1'b0;
        applied++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared_on_start: got %b, required 0", err); end
        in_valid = 1'b1;
        in_data  = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        applied++;
        if ({in_ready, acc_en, acc_rst, acc_pre, res_valid, busy, err} !== 7'b0 ||
            acc_vals !== '0 || res_data !== '0) begin
            miscompares++;
            $display("FAIL midfill_reset: ctrl=%b res_data=%h, required all 0",
                     {in_ready, acc_en, acc_rst, acc_pre, res_valid, busy, err}, res_data);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_stream(3, 1, '0, 1'b0, 1'b0, 0, got);
        applied++;
        if (got !== 32'd60) begin miscompares++; $display("FAIL after_reset_sum: got %0d, required 60", got); end
        applied++;
        if (n_overlap !== 0) begin miscompares++; $display("FAIL en_rst_overlap: got %0d cycles, required 0", n_overlap); end
    endtask

    initial begin
        test_reset();
        test_full_chunk();
        test_partial_chunk();
        test_chain();
        test_len_zero();
        test_back_to_back_gaps();
        test_timeout();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
